// File: rtl/servo_motion_sequencer_if.sv
// rtl/servo_motion_sequencer_if.sv - joystick sample in, servo commands and status out
interface servo_motion_sequencer_if;
   logic        sample_valid;
   logic [9:0]  x_pos;
   logic [9:0]  y_pos;
   logic        center_btn;
   logic [3:0]  sel;
   logic [11:0] servo0_cmd;
   logic [11:0] servo1_cmd;
   logic [11:0] servo2_cmd;
   logic [11:0] servo3_cmd;
   logic        busy;
   logic        sample_drop;
   logic        frame_done;

   modport master (
      output sample_valid, x_pos, y_pos, center_btn, sel,
      input  servo0_cmd, servo1_cmd, servo2_cmd, servo3_cmd, busy, sample_drop, frame_done
   );

   modport slave (
      input  sample_valid, x_pos, y_pos, center_btn, sel,
      output servo0_cmd, servo1_cmd, servo2_cmd, servo3_cmd, busy, sample_drop, frame_done
   );
endinterface

// File: rtl/servo_motion_sequencer.sv
// rtl/servo_motion_sequencer.sv - joystick-to-servo target mapping with per-frame slew limiting
module servo_motion_sequencer #(
   parameter int CLK_HZ    = 12000000,
   parameter int UPDATE_HZ = 50,
   parameter int JOY_MIN   = 228,
   parameter int JOY_MAX   = 830,
   parameter int MIN_US    = 650,
   parameter int MAX_US    = 2600,
   parameter int CENTER_US = 1500,
   parameter int STEP_US   = 20
) (
   input logic                     CLK,
   input logic                     RST_N,
   servo_motion_sequencer_if.slave bus
);
   localparam int              FRAME_LEN  = CLK_HZ / UPDATE_HZ;
   localparam int              FCW        = $clog2(FRAME_LEN);
   localparam logic [FCW-1:0]  FRAME_LAST = FCW'(FRAME_LEN - 1);
   localparam logic [9:0]      JMIN       = 10'(JOY_MIN);
   localparam logic [9:0]      JMAX       = 10'(JOY_MAX);
   localparam logic [10:0]     DIVISOR    = 11'(JOY_MAX - JOY_MIN);
   localparam logic [20:0]     SPAN       = 21'(MAX_US - MIN_US);
   localparam logic [11:0]     MIN_W      = 12'(MIN_US);
   localparam logic [11:0]     CENTER_W   = 12'(CENTER_US);
   localparam logic [11:0]     STEP_W     = 12'(STEP_US);
   localparam logic [3:0]      LAST_BIT   = 4'd10;

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, STEP} state_t;

   function automatic logic [20:0] scaled(input logic [9:0] p);
      logic [9:0] pc;
      pc = (p < JMIN) ? JMIN : ((p > JMAX) ? JMAX : p);
      return 21'(pc - JMIN) * SPAN;
   endfunction

   state_t          state_q, state_d;
   logic [FCW-1:0]  fcnt_q;
   logic            tick_q;
   logic [3:0]      cnt_q;
   logic [1:0]      ch_q;
   logic [9:0]      rem_q;
   logic [10:0]     dsr_q, quo_q, qx_q;
   logic [9:0]      y_q;
   logic            center_q;
   logic [3:0]      sel_q;
   logic [11:0]     tgt_q [4];
   logic [11:0]     cmd_q [4];
   logic            drop_q, done_q;

   logic            wrap, accept, div_last, ge;
   logic [10:0]     trial, quo_nx;
   logic [9:0]      rem_nx;
   logic [20:0]     dvd_x, dvd_y;
   logic [11:0]     us_x, us_y, cur, tgt, diff, slew_nx;

   assign wrap     = (fcnt_q == FRAME_LAST);
   assign accept   = (state_q == IDLE) && !tick_q && bus.sample_valid;
   assign div_last = (cnt_q == LAST_BIT);

   // Remainder starts as the top 10 dividend bits: the quotient always fits in 11 bits.
   assign trial  = {rem_q, dsr_q[10]};
   assign ge     = (trial >= DIVISOR);
   assign rem_nx = ge ? 10'(trial - DIVISOR) : trial[9:0];
   assign quo_nx = {quo_q[9:0], ge};
   assign dvd_x  = scaled(bus.x_pos);
   assign dvd_y  = scaled(y_q);
   assign us_x   = MIN_W + {1'b0, qx_q};
   assign us_y   = MIN_W + {1'b0, quo_nx};

   always_comb begin
      cur     = cmd_q[ch_q];
      tgt     = tgt_q[ch_q];
      diff    = '0;
      slew_nx = cur;
      if (cur < tgt) begin
         diff    = tgt - cur;
         slew_nx = cur + ((diff > STEP_W) ? STEP_W : diff);
      end else if (cur > tgt) begin
         diff    = cur - tgt;
         slew_nx = cur - ((diff > STEP_W) ? STEP_W : diff);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (tick_q)                state_d = STEP;
            else if (bus.sample_valid) state_d = DIV_X;
         end
         DIV_X:   if (div_last) state_d = DIV_Y;
         DIV_Y:   if (div_last) state_d = IDLE;
         STEP:    if (ch_q == 2'd3) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fcnt_q   <= '0;
         tick_q   <= 1'b0;
         cnt_q    <= '0;
         ch_q     <= '0;
         rem_q    <= '0;
         dsr_q    <= '0;
         quo_q    <= '0;
         qx_q     <= '0;
         y_q      <= '0;
         center_q <= 1'b0;
         sel_q    <= '0;
         drop_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            tgt_q[i] <= CENTER_W;
            cmd_q[i] <= CENTER_W;
         end
      end else begin
         fcnt_q <= wrap ? '0 : fcnt_q + 1'b1;
         if (wrap)                            tick_q <= 1'b1;
         else if (state_q == IDLE && tick_q)  tick_q <= 1'b0;

         drop_q <= bus.sample_valid && !accept;
         done_q <= (state_q == STEP) && (ch_q == 2'd3);

         if (state_q == DIV_X || state_q == DIV_Y) cnt_q <= div_last ? '0 : cnt_q + 4'd1;
         else                                      cnt_q <= '0;
         if (state_q == STEP) ch_q <= ch_q + 2'd1;
         else                 ch_q <= '0;

         if (accept) begin
            rem_q    <= dvd_x[20:11];
            dsr_q    <= dvd_x[10:0];
            quo_q    <= '0;
            y_q      <= bus.y_pos;
            center_q <= bus.center_btn;
            sel_q    <= bus.sel;
         end else if (state_q == DIV_X && div_last) begin
            qx_q  <= quo_nx;
            rem_q <= dvd_y[20:11];
            dsr_q <= dvd_y[10:0];
            quo_q <= '0;
         end else if (state_q == DIV_X || (state_q == DIV_Y && !div_last)) begin
            rem_q <= rem_nx;
            dsr_q <= {dsr_q[9:0], 1'b0};
            quo_q <= quo_nx;
         end else if (state_q == DIV_Y) begin
            for (int i = 0; i < 4; i++) begin
               if (sel_q[i]) tgt_q[i] <= center_q ? CENTER_W : (((i % 2) == 1) ? us_y : us_x);
            end
         end

         if (state_q == STEP) cmd_q[ch_q] <= slew_nx;
      end
   end

   assign bus.servo0_cmd  = cmd_q[0];
   assign bus.servo1_cmd  = cmd_q[1];
   assign bus.servo2_cmd  = cmd_q[2];
   assign bus.servo3_cmd  = cmd_q[3];
   assign bus.busy        = (state_q != IDLE);
   assign bus.sample_drop = drop_q;
   assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// tb/tb_servo_motion_sequencer.sv - scoreboard bench for servo_motion_sequencer with a 100-cycle frame
module tb_servo_motion_sequencer;
   localparam int FRAME_LEN = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   servo_motion_sequencer_if bus ();

   servo_motion_sequencer #(
      .CLK_HZ    (12000000),
      .UPDATE_HZ (120000)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   typedef struct { int c0; int c1; int c2; int c3; } frame_t;
   typedef struct { int run; int gap; } busy_t;

   frame_t frame_q[$];
   busy_t  busy_q[$];
   int     drop_q[$];
   int     tests = 0;
   int     fails = 0;
   int     frames_seen = 0;
   int     tgt[4];
   int     cmd[4];

   frame_t fe;
   busy_t  be;
   int     brun = 0, bgap = 0, bgap_start = 0;

   // Frame monitor: every frame_done pops the expected command set.
   always @(negedge clk) begin
      if (rst_n && bus.frame_done) begin
         frames_seen++;
         tests++;
         if (frame_q.size() == 0) begin
            fails++;
            $display("FAIL frame_unexpected: frame %0d arrived with nothing expected", frames_seen);
         end else begin
            fe = frame_q.pop_front();
            if (int'(bus.servo0_cmd) != fe.c0 || int'(bus.servo1_cmd) != fe.c1 ||
                int'(bus.servo2_cmd) != fe.c2 || int'(bus.servo3_cmd) != fe.c3) begin
               fails++;
               $display("FAIL frame_%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", frames_seen,
                        bus.servo0_cmd, bus.servo1_cmd, bus.servo2_cmd, bus.servo3_cmd,
                        fe.c0, fe.c1, fe.c2, fe.c3);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus.sample_drop) begin
         tests++;
         if (drop_q.size() == 0) begin
            fails++;
            $display("FAIL drop_unexpected: sample_drop=1 expected 0");
         end else begin
            void'(drop_q.pop_front());
         end
      end
   end

   // Busy monitor: checks each busy run length and, optionally, the idle gap before it.
   always @(negedge clk) begin
      if (!rst_n) begin
         brun = 0;
         bgap = 0;
      end else if (bus.busy) begin
         if (brun == 0) bgap_start = bgap;
         brun++;
      end else begin
         if (brun > 0) begin
            tests++;
            if (busy_q.size() == 0) begin
               fails++;
               $display("FAIL busy_unexpected: run of %0d cycles with nothing expected", brun);
            end else begin
               be = busy_q.pop_front();
               if (brun != be.run || (be.gap >= 0 && bgap_start != be.gap)) begin
                  fails++;
                  $display("FAIL busy_run: got run %0d gap %0d expected run %0d gap %0d",
                           brun, bgap_start, be.run, be.gap);
               end
            end
            brun = 0;
            bgap = 0;
         end
         bgap++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_cmd0"}, int'(bus.servo0_cmd), 1500);
      check({tag, "_cmd1"}, int'(bus.servo1_cmd), 1500);
      check({tag, "_cmd2"}, int'(bus.servo2_cmd), 1500);
      check({tag, "_cmd3"}, int'(bus.servo3_cmd), 1500);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_drop"}, int'(bus.sample_drop), 0);
      check({tag, "_done"}, int'(bus.frame_done), 0);
   endtask

   task automatic push_busy(input int r, input int g);
      busy_t b;
      b.run = r;
      b.gap = g;
      busy_q.push_back(b);
   endtask

   task automatic drive_pulse(input logic [3:0] s, input logic [9:0] x, input logic [9:0] y, input logic c);
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sel          = s;
      bus.x_pos        = x;
      bus.y_pos        = y;
      bus.center_btn   = c;
      @(negedge clk);
      bus.sample_valid = 1'b0;
   endtask

   task automatic set_targets(input logic [3:0] s, input bit c, input int tx, input int ty);
      for (int i = 0; i < 4; i++)
         if (s[i]) tgt[i] = c ? 1500 : (((i % 2) == 1) ? ty : tx);
   endtask

   task automatic model_frame();
      frame_t f;
      for (int i = 0; i < 4; i++) begin
         if (cmd[i] < tgt[i])      cmd[i] += ((tgt[i] - cmd[i]) > 20) ? 20 : (tgt[i] - cmd[i]);
         else if (cmd[i] > tgt[i]) cmd[i] -= ((cmd[i] - tgt[i]) > 20) ? 20 : (cmd[i] - tgt[i]);
      end
      f.c0 = cmd[0];
      f.c1 = cmd[1];
      f.c2 = cmd[2];
      f.c3 = cmd[3];
      frame_q.push_back(f);
   endtask

   task automatic wait_frame();
      int n;
      for (n = 0; n < 3 * FRAME_LEN; n++) begin
         @(negedge clk);
         if (bus.frame_done) break;
      end
      tests++;
      if (n >= 3 * FRAME_LEN) begin
         fails++;
         $display("FAIL frame_timeout: no frame_done within %0d cycles", 3 * FRAME_LEN);
      end
   endtask

   task automatic run_frame(input bit smp, input logic [3:0] s, input logic [9:0] x, input logic [9:0] y,
                            input bit c, input int tx, input int ty);
      if (smp) begin
         push_busy(22, -1);
         drive_pulse(s, x, y, c);
         set_targets(s, c, tx, ty);
      end
      model_frame();
      push_busy(4, -1);
      wait_frame();
   endtask

   task automatic model_reset();
      frame_q.delete();
      busy_q.delete();
      drop_q.delete();
      for (int i = 0; i < 4; i++) begin
         tgt[i] = 1500;
         cmd[i] = 1500;
      end
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.sel          = '0;
      bus.x_pos        = '0;
      bus.y_pos        = '0;
      bus.center_btn   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_state("rst_low");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state("rst_rel");

      repeat (10) run_frame(0, 4'b0000, 0, 0, 0, 0, 0);
      #1;
      check("idle_frame_count", frames_seen, 10);

      // Full-scale ramp on channel 0 only: 55 frames of +20 from 1500.
      run_frame(1, 4'b0001, 830, 512, 0, 2600, 0);
      repeat (55) run_frame(0, 4'b0000, 0, 0, 0, 0, 0);
      check("ramp_cmd0", int'(bus.servo0_cmd), 2600);
      check("ramp_cmd1", int'(bus.servo1_cmd), 1500);

      // x=529 -> 1625 exactly; y=228 -> 650; channel 2 ends with a 5us step.
      run_frame(1, 4'b1111, 529, 228, 0, 1625, 650);
      repeat (49) run_frame(0, 4'b0000, 0, 0, 0, 0, 0);
      check("map_cmd0", int'(bus.servo0_cmd), 1625);
      check("map_cmd1", int'(bus.servo1_cmd), 650);
      check("map_cmd2", int'(bus.servo2_cmd), 1625);
      run_frame(1, 4'b1111, 1000, 100, 0, 2600, 650);
      repeat (2) run_frame(0, 4'b0000, 0, 0, 0, 0, 0);

      // Sample during DIV_Y is dropped; the accepted one selects no channels.
      push_busy(22, -1);
      drive_pulse(4'b0000, 0, 0, 0);
      repeat (13) @(negedge clk);
      drop_q.push_back(1);
      drive_pulse(4'b1111, 830, 830, 0);
      model_frame();
      push_busy(4, -1);
      wait_frame();

      // Frame wrap lands in DIV_X: STEP follows after a single IDLE cycle.
      repeat (89) @(negedge clk);
      push_busy(22, -1);
      push_busy(4, 1);
      drive_pulse(4'b0001, 529, 0, 0);
      set_targets(4'b0001, 0, 1625, 0);
      model_frame();
      wait_frame();
      run_frame(0, 4'b0000, 0, 0, 0, 0, 0);

      // Sample in the IDLE cycle that leaves for STEP is dropped.
      repeat (94) @(negedge clk);
      drop_q.push_back(1);
      push_busy(4, -1);
      drive_pulse(4'b1111, 830, 830, 0);
      model_frame();
      wait_frame();

      // Reset at DIV_X cycle 5 aborts the sample.
      drive_pulse(4'b1111, 830, 830, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_state("rst_mid");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // x=y=645 maps to 2000.
      run_frame(1, 4'b1111, 645, 645, 0, 2000, 2000);
      repeat (24) run_frame(0, 4'b0000, 0, 0, 0, 0, 0);
      check("post_rst_cmd0", int'(bus.servo0_cmd), 2000);
      check("post_rst_cmd3", int'(bus.servo3_cmd), 2000);

      run_frame(1, 4'b0110, 300, 900, 1, 0, 0);
      repeat (25) run_frame(0, 4'b0000, 0, 0, 0, 0, 0);
      check("center_cmd0", int'(bus.servo0_cmd), 2000);
      check("center_cmd1", int'(bus.servo1_cmd), 1500);
      check("center_cmd2", int'(bus.servo2_cmd), 1500);
      check("center_cmd3", int'(bus.servo3_cmd), 2000);

      repeat (5) @(negedge clk);
      check("frame_q_left", frame_q.size(), 0);
      check("busy_q_left", busy_q.size(), 0);
      check("drop_q_left", drop_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
